// File: rtl/edge_detector_bank.sv
// edge_detector_bank: per-channel synchroniser, debounce filter and
// programmable edge pulse generator (rising / falling / both / disabled).
// Optional sticky pending flags with interrupt: define EDGE_STICKY_EN.
module edge_detector_bank #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     sigin,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [CHANNELS-1:0]     clr,
    output logic [CHANNELS-1:0]     level,
    output logic [CHANNELS-1:0]     sigout,
    output logic [CHANNELS-1:0]     pend,
    output logic                    irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] sigout_d;
    logic [CHANNELS-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

    // Input synchroniser chains, one bit per channel per stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sigin;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Debounce counters, level update and mode-qualified edge decode
    always_comb begin
        level_d  = level;
        sigout_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[i]   = '0;
                level_d[i] = s[i];
                // Rising: modes 00/10; falling: modes 01/10; 11 never pulses
                if (s[i]) begin
                    sigout_d[i] = (mode[2*i +: 2] == 2'b00) || (mode[2*i +: 2] == 2'b10);
                end else begin
                    sigout_d[i] = (mode[2*i +: 2] == 2'b01) || (mode[2*i +: 2] == 2'b10);
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounce state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            level  <= '0;
            sigout <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level  <= level_d;
            sigout <= sigout_d;
        end
    end

`ifdef EDGE_STICKY_EN
    // Sticky pending flags: a new edge wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | sigout_d;
        end
    end

    assign irq = |pend;
`else
    logic unused_clr;

    assign unused_clr = ^clr;
    assign pend       = '0;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_edge_detector_bank.sv
// Directed bench for edge_detector_bank with a per-cycle scoreboard.
module tb_edge_detector_bank;

    localparam int unsigned CH = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;
`ifdef EDGE_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   sigin;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   level;
    logic [CH-1:0]   sigout;
    logic [CH-1:0]   pend;
    logic            irq;

    always #5 clk = ~clk;

    edge_detector_bank #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sigin  (sigin),
        .mode   (mode),
        .clr    (clr),
        .level  (level),
        .sigout (sigout),
        .pend   (pend),
        .irq    (irq)
    );

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] out;
        logic [CH-1:0] pnd;
        logic          irq;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [CH-1:0] m_sync [SS];
    int            m_cnt  [CH];
    logic [CH-1:0] m_lvl;
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sync[k] = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_lvl  = '0;
        m_out  = '0;
        m_pend = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        logic [CH-1:0] s;
        logic [CH-1:0] nlvl;
        logic [CH-1:0] nout;
        logic [1:0]    md;
        obs_t          e;
        s    = m_sync[SS-1];
        nlvl = m_lvl;
        nout = '0;
        for (int i = 0; i < CH; i++) begin
            md = mode[2*i +: 2];
            if (s[i] == m_lvl[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] == DB - 1) begin
                m_cnt[i] = 0;
                nlvl[i]  = s[i];
                if (s[i] && (md == 2'd0 || md == 2'd2)) nout[i] = 1'b1;
                if (!s[i] && (md == 2'd1 || md == 2'd2)) nout[i] = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = sigin;
        if (STICKY) m_pend = (m_pend & ~clr) | nout;
        else        m_pend = '0;
        m_lvl = nlvl;
        m_out = nout;
        e.lvl = m_lvl;
        e.out = m_out;
        e.pnd = m_pend;
        e.irq = |m_pend;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        obs_t e;
        obs_t a;
        a = {level, sigout, pend, irq};
        if (exp_q.size() == 0) begin
            chk({tag, "_noexp"}, 32'(a), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(a), 32'(e));
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    int pulses;
    int rise;
    int fall;
    int tog;
    logic acc;
    logic prev;

    initial begin
        rst   = 1'b1;
        sigin = '0;
        mode  = '0;
        clr   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        check_out("reset");

        // Reset release with all inputs high: rising edges at edge 6
        rst   = 1'b0;
        sigin = 4'hF;
        for (int e = 1; e <= 7; e++) begin
            tick("release");
            if (e <= 5) chk("release_level_low", 32'(level), 32'h0);
            if (e == 6) begin
                chk("release_level_f", 32'(level), 32'hF);
                chk("release_pulse_f", 32'(sigout), 32'hF);
            end
            if (e == 7) chk("release_pulse_end", 32'(sigout), 32'h0);
        end
        sigin = '0;
        repeat (8) tick("settle");

        // Three-cycle glitch on ch0 is filtered
        acc = 1'b0;
        for (int k = 0; k < 12; k++) begin
            sigin[0] = (k < 3);
            tick("glitch3");
            acc = acc | level[0] | sigout[0];
        end
        chk("glitch3_quiet", 32'(acc), 32'h0);

        // Four-cycle pulse on ch0 passes with a single pulse
        pulses = 0;
        acc    = 1'b0;
        for (int k = 0; k < 14; k++) begin
            sigin[0] = (k < 4);
            tick("glitch4");
            if (sigout[0]) pulses++;
            acc = acc | level[0];
        end
        chk("glitch4_pulses", 32'(pulses), 32'd1);
        chk("glitch4_level_seen", 32'(acc), 32'h1);

        // Mode sweep on ch1
        for (int md = 0; md < 4; md++) begin
            mode = 8'(md << 2);
            rise = 0;
            fall = 0;
            tog  = 0;
            prev = level[1];
            for (int k = 0; k < 24; k++) begin
                sigin[1] = (k < 10);
                tick("mode_sweep");
                if (sigout[1]) begin
                    if (level[1]) rise++;
                    else          fall++;
                end
                if (level[1] != prev) tog++;
                prev = level[1];
            end
            chk("mode_rise", 32'(rise), (md == 0 || md == 2) ? 32'd1 : 32'd0);
            chk("mode_fall", 32'(fall), (md == 1 || md == 2) ? 32'd1 : 32'd0);
            chk("mode_toggles", 32'(tog), 32'd2);
        end

        // Re-enable while level high: no false edge
        mode     = 8'b0000_1100;
        sigin[1] = 1'b1;
        repeat (8) tick("reenable_hold");
        mode   = '0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick("reenable");
            if (sigout[1]) pulses++;
        end
        chk("reenable_pulses", 32'(pulses), 32'd0);
        chk("reenable_level", 32'(level[1]), 32'h1);
        sigin[1] = 1'b0;
        repeat (8) tick("reenable_fall");

        // Async reset in the middle of a ch2 debounce
        sigin = 4'b0001;
        repeat (8) tick("pre_rst");
        sigin = 4'b0101;
        repeat (4) tick("mid_debounce");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        exp_q.push_back('0);
        check_out("async_rst");
        chk("async_rst_level", 32'(level), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick("post_rst");
            if (e < 6)  chk("post_rst_quiet", 32'(sigout), 32'h0);
            if (e == 6) chk("post_rst_pulse", 32'(sigout), 32'b0101);
        end

        // Sticky pending flags on ch3
        clr = 4'hF;
        tick("clear_all");
        clr = '0;
        tick("clear_all_done");
        chk("clear_all_pend", 32'(pend), 32'h0);
        sigin = 4'b1101;
        repeat (6) tick("sticky_rise");
        chk("sticky_pulse", 32'(sigout[3]), 32'h1);
        chk("sticky_pend", 32'(pend[3]), 32'(STICKY));
        chk("sticky_irq", 32'(irq), 32'(STICKY));
        tick("sticky_hold");
        chk("sticky_hold_pend", 32'(pend[3]), 32'(STICKY));
        clr = 4'b1000;
        tick("sticky_clr");
        clr = '0;
        chk("sticky_clr_pend", 32'(pend[3]), 32'h0);
        chk("sticky_clr_irq", 32'(irq), 32'h0);

        // Clear coinciding with a new edge: set wins
        mode  = 8'b1000_0000;
        sigin = 4'b0101;
        repeat (5) tick("collide_pre");
        clr = 4'b1000;
        tick("collide");
        clr = '0;
        chk("collide_pulse", 32'(sigout[3]), 32'h1);
        chk("collide_pend", 32'(pend[3]), 32'(STICKY));
        tick("collide_after");
        chk("collide_after_irq", 32'(irq), 32'(STICKY));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
